// File: rtl/rgb_fade_seq.sv
`default_nettype none
// ============================================================================
// Module   : rgb_fade_seq
// Brief    : Prescaled R->G->B->R colour-wheel fade sequencer that drives the
//            3-channel PWM stage. Optional gamma stage: RGB_FADE_GAMMA_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_fade_seq #(
  parameter int PRESCALE  = 128,
  parameter int STEP      = 1,
  parameter int MAX_LEVEL = 255
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       hold,
  input  logic       restart,
  output logic [7:0] val0,
  output logic [7:0] val1,
  output logic [7:0] val2,
  output logic       load,
  output logic [1:0] phase,
  output logic       wrap
);

  typedef enum logic [1:0] {
    c_PH_R2G = 2'd0,
    c_PH_G2B = 2'd1,
    c_PH_B2R = 2'd2
  } phase_t;

  localparam logic [15:0]     c_PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [8:0]      c_STEP       = 9'(STEP);
  localparam logic [8:0]      c_MAX        = 9'(MAX_LEVEL);
  localparam logic [2:0][7:0] c_LIN_RST    = {8'd0, 8'd0, c_MAX[7:0]};

  phase_t          r_phase;
  phase_t          w_phase_nxt;
  phase_t          w_phase_adv;
  logic [2:0][7:0] r_lin;
  logic [2:0][7:0] w_lin_nxt;
  logic [15:0]     r_presc;
  logic [15:0]     w_presc_nxt;
  logic            r_load;
  logic            w_load_nxt;
  logic            r_wrap;
  logic            w_wrap_nxt;
  logic            r_init;
  logic            w_step;
  logic [1:0]      w_fall_idx;
  logic [1:0]      w_rise_idx;
  logic [8:0]      w_fall;
  logic [8:0]      w_rise;

  // Which channel falls, which rises, and where the phase goes on completion.
  always_comb begin
    w_fall_idx  = 2'd0;
    w_rise_idx  = 2'd1;
    w_phase_adv = c_PH_G2B;
    case (r_phase)
      c_PH_G2B: begin
        w_fall_idx  = 2'd1;
        w_rise_idx  = 2'd2;
        w_phase_adv = c_PH_B2R;
      end
      c_PH_B2R: begin
        w_fall_idx  = 2'd2;
        w_rise_idx  = 2'd0;
        w_phase_adv = c_PH_R2G;
      end
      default: ;
    endcase
  end

  assign w_fall = {1'b0, r_lin[w_fall_idx]};
  assign w_rise = {1'b0, r_lin[w_rise_idx]};
  assign w_step = en & ~hold & ~r_init & (r_presc == c_PRESC_LAST);

  // The init cycle keeps the prescaler at zero so the first step lands a full
  // PRESCALE clocks after the priming load.
  always_comb begin
    w_presc_nxt = r_presc + 16'd1;
    if (restart || r_init || !en) begin
      w_presc_nxt = '0;
    end else if (hold) begin
      w_presc_nxt = r_presc;
    end else if (r_presc == c_PRESC_LAST) begin
      w_presc_nxt = '0;
    end
  end

  always_comb begin
    w_lin_nxt   = r_lin;
    w_phase_nxt = r_phase;
    w_load_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (restart) begin
      w_lin_nxt   = c_LIN_RST;
      w_phase_nxt = c_PH_R2G;
      w_load_nxt  = 1'b1;
    end else if (r_init) begin
      w_load_nxt = 1'b1;
    end else if (w_step) begin
      w_load_nxt = 1'b1;
      // Compare before subtracting so the falling channel never underflows.
      if (w_fall > c_STEP) begin
        w_lin_nxt[w_fall_idx] = 8'(w_fall - c_STEP);
        w_lin_nxt[w_rise_idx] = 8'(w_rise + c_STEP);
      end else begin
        w_lin_nxt[w_fall_idx] = 8'd0;
        w_lin_nxt[w_rise_idx] = c_MAX[7:0];
        w_phase_nxt           = w_phase_adv;
        w_wrap_nxt            = (r_phase == c_PH_B2R);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lin   <= c_LIN_RST;
      r_phase <= c_PH_R2G;
      r_presc <= '0;
      r_load  <= 1'b0;
      r_wrap  <= 1'b0;
      r_init  <= 1'b1;
    end else begin
      r_lin   <= w_lin_nxt;
      r_phase <= w_phase_nxt;
      r_presc <= w_presc_nxt;
      r_load  <= w_load_nxt;
      r_wrap  <= w_wrap_nxt;
      r_init  <= 1'b0;
    end
  end

`ifdef RGB_FADE_GAMMA_EN
  typedef logic [7:0] lut_t [256];

  // Table is evaluated at elaboration only; no real arithmetic reaches gates.
  function automatic lut_t f_gamma_lut();
    lut_t lut;
    real  x;
    for (int i = 0; i < 256; i++) begin
      x      = 255.0 * ((real'(i) / 255.0) ** 2.2);
      lut[i] = 8'($rtoi(x + 0.5));
    end
    return lut;
  endfunction

  localparam lut_t c_GAMMA_LUT = f_gamma_lut();

  logic [2:0][7:0] r_gam;
  logic            r_load_d;
  logic            r_wrap_d;
  logic [1:0]      r_phase_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gam     <= {8'd0, 8'd0, c_GAMMA_LUT[MAX_LEVEL]};
      r_load_d  <= 1'b0;
      r_wrap_d  <= 1'b0;
      r_phase_d <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_gam[i] <= c_GAMMA_LUT[r_lin[i]];
      end
      r_load_d  <= r_load;
      r_wrap_d  <= r_wrap;
      r_phase_d <= r_phase;
    end
  end

  assign val0  = r_gam[0];
  assign val1  = r_gam[1];
  assign val2  = r_gam[2];
  assign load  = r_load_d;
  assign wrap  = r_wrap_d;
  assign phase = r_phase_d;
`else
  assign val0  = r_lin[0];
  assign val1  = r_lin[1];
  assign val2  = r_lin[2];
  assign load  = r_load;
  assign wrap  = r_wrap;
  assign phase = r_phase;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_fade_seq
// Brief    : Scoreboard bench for rgb_fade_seq (two parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_fade_seq;

  localparam int PRE = 4;
`ifdef RGB_FADE_GAMMA_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       en = 1'b1;
  logic       hold = 1'b0;
  logic       restart = 1'b0;
  logic       en_b = 1'b1;
  logic       hold_b = 1'b0;
  logic       restart_b = 1'b0;
  logic [7:0] a0, a1, a2, b0, b1, b2;
  logic       a_load, a_wrap, b_load, b_wrap;
  logic [1:0] a_ph, b_ph;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int wraps_a = 0;
  int t;
  int m[3];
  int mph;

  typedef struct {
    int cyc;
    int v0;
    int v1;
    int v2;
    int ph;
    int wr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  rgb_fade_seq #(.PRESCALE(PRE), .STEP(1), .MAX_LEVEL(255)) dut_a (
    .clk(clk), .resetn(resetn), .en(en), .hold(hold), .restart(restart),
    .val0(a0), .val1(a1), .val2(a2), .load(a_load), .phase(a_ph), .wrap(a_wrap)
  );

  rgb_fade_seq #(.PRESCALE(PRE), .STEP(5), .MAX_LEVEL(128)) dut_b (
    .clk(clk), .resetn(resetn), .en(en_b), .hold(hold_b), .restart(restart_b),
    .val0(b0), .val1(b1), .val2(b2), .load(b_load), .phase(b_ph), .wrap(b_wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gout(input int x);
`ifdef RGB_FADE_GAMMA_EN
    return $rtoi(255.0 * ((real'(x) / 255.0) ** 2.2) + 0.5);
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Reference colour wheel for the STEP=1, MAX_LEVEL=255 instance.
  task automatic a_step(output int w);
    int f, r;
    f = mph;
    r = (mph + 1) % 3;
    w = 0;
    if (m[f] > 1) begin
      m[f] = m[f] - 1;
      m[r] = m[r] + 1;
    end else begin
      m[f] = 0;
      m[r] = 255;
      mph  = r;
      w    = (f == 2) ? 1 : 0;
    end
  endtask

  task automatic push_a(input int at, input int w);
    qa.push_back('{at + LAT, gout(m[0]), gout(m[1]), gout(m[2]), mph, w});
  endtask

  task automatic run_steps(input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      a_step(w);
      t += PRE;
      push_a(t, w);
      wait_until(t + LAT);
    end
  endtask

  // Monitor A: every load must match the head of the queue, cycle included.
  always @(negedge clk) begin
    if (a_load) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_load", 1, 0);
      end else begin
        ea = qa.pop_front();
        chk("a_load_cycle", cyc, ea.cyc);
        chk("a_val0", int'(a0), ea.v0);
        chk("a_val1", int'(a1), ea.v1);
        chk("a_val2", int'(a2), ea.v2);
        chk("a_phase", int'(a_ph), ea.ph);
        chk("a_wrap", int'(a_wrap), ea.wr);
      end
`ifndef RGB_FADE_GAMMA_EN
      chk("a_sum", int'(a0) + int'(a1) + int'(a2), 255);
      chk("a_zero_channel", int'(a0 == 0 || a1 == 0 || a2 == 0), 1);
`endif
      if (a_wrap) wraps_a++;
    end else if (a_wrap) begin
      chk("a_wrap_without_load", 1, 0);
    end
  end

  // Monitor B: queued directed values first, ceiling checks on every load.
  always @(negedge clk) begin
    if (b_load) begin
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        chk("b_load_cycle", cyc, eb.cyc);
        chk("b_val0", int'(b0), eb.v0);
        chk("b_val1", int'(b1), eb.v1);
        chk("b_val2", int'(b2), eb.v2);
        chk("b_phase", int'(b_ph), eb.ph);
      end
      chk("b_ceiling", int'(b0 <= 128 && b1 <= 128 && b2 <= 128), 1);
`ifndef RGB_FADE_GAMMA_EN
      chk("b_sum", int'(b0) + int'(b1) + int'(b2), 128);
`endif
    end
  end

  initial begin
    int w;
    m   = '{255, 0, 0};
    mph = 0;

    // Asynchronous reset before any clock edge.
    #2 resetn = 1'b0;
    #1;
    chk("rst_a_val0", int'(a0), gout(255));
    chk("rst_a_val1", int'(a1), 0);
    chk("rst_a_val2", int'(a2), 0);
    chk("rst_a_load", int'(a_load), 0);
    chk("rst_a_wrap", int'(a_wrap), 0);
    chk("rst_a_phase", int'(a_ph), 0);
    chk("rst_b_val0", int'(b0), gout(128));

    wait_until(3);
    t = cyc + 1;
    push_a(t, 0);
    qb.push_back('{t + LAT, gout(128), 0, 0, 0, 0});
    for (int k = 1; k <= 25; k++)
      qb.push_back('{t + PRE * k + LAT, gout(128 - 5 * k), gout(5 * k), 0, 0, 0});
    qb.push_back('{t + PRE * 26 + LAT, 0, gout(128), 0, 1, 0});
    resetn = 1'b1;
    wait_until(t + LAT);

    // Advance into G2B, then restart exactly on a step edge.
    run_steps(300);
    wait_until(t + PRE - 1);
    restart = 1'b1;
    t += PRE;
    m   = '{255, 0, 0};
    mph = 0;
    push_a(t, 0);
    wait_until(t);
    restart = 1'b0;

    // One full colour cycle: 3 * 255 steps, single wrap at the end.
    run_steps(765);

    // Hold for 10 clocks while the prescaler sits at 2.
    a_step(w);
    push_a(t + 14, w);
    wait_until(t + 2);
    hold = 1'b1;
    wait_until(t + 12);
    hold = 1'b0;
    t += 14;
    wait_until(t + LAT);
    run_steps(2);

    // One clock of en=0 clears the prescaler: next load PRESCALE+1 clocks on.
    a_step(w);
    push_a(t + 6, w);
    wait_until(t + 1);
    en = 1'b0;
    wait_until(t + 2);
    en = 1'b1;
    t += 6;
    wait_until(t + LAT);
    run_steps(3);

    // Reset mid-run clears outputs without waiting for a clock.
    wait_until(t + 2);
    resetn = 1'b0;
    #1;
    chk("midrst_a_val0", int'(a0), gout(255));
    chk("midrst_a_val1", int'(a1), 0);
    chk("midrst_a_val2", int'(a2), 0);
    chk("midrst_a_phase", int'(a_ph), 0);
    chk("midrst_a_load", int'(a_load), 0);
    wait_until(cyc + 3);
    m   = '{255, 0, 0};
    mph = 0;
    t   = cyc + 1;
    push_a(t, 0);
    resetn = 1'b1;
    wait_until(t + LAT);
    run_steps(3);

    wait_until(t + 2);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    chk("a_wrap_count", wraps_a, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb_fade_seq.md
Name: rgb_fade_seq

Overview:
- Upstream colour sequencer for the 3-channel RGB PWM stage.
- Generates three 8-bit duty values that walk the colour wheel R->G->B->R, plus a one-cycle load strobe that drives the PWM block's enable/latch input.
- Replaces the hand-coded fade logic in the top level with a parameterised, prescaled, restartable block.

Parameters:
- PRESCALE, 128: clocks per fade step; legal range 2..65535.
- STEP, 1: duty increment per step; legal range 1..MAX_LEVEL.
- MAX_LEVEL, 255: channel ceiling; set to 128 for half brightness; legal range 1..255.

Ports:
- clk  input  1  single system clock (LFOSC domain).
- resetn  input  1  asynchronous active-low reset.
- en  input  1  run enable; when 0, the prescaler is cleared and values are frozen.
- hold  input  1  pause; the prescaler and values are frozen, and the prescaler is not cleared.
- restart  input  1  synchronous one-cycle request to return to the start colour.
- val0  output  8  red duty, to PWM value_input0.
- val1  output  8  green duty, to PWM value_input1.
- val2  output  8  blue duty, to PWM value_input2.
- load  output  1  one-cycle strobe; val0..2 are valid and updated in this cycle.
- phase  output  2  0=R2G, 1=G2B, 2=B2R; 3 is never produced.
- wrap  output  1  one-cycle pulse when B2R completes.

Behaviour:
- Reset (resetn=0, asynchronous), all outputs and internal state take these values:
  - val0=MAX_LEVEL, val1=0, val2=0
  - phase=0, prescaler=0
  - load=0, wrap=0
  - init flag set.
- First clock after reset release: load=1 for one cycle with the reset values, and the init flag is cleared. This primes the PWM regardless of en.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1 and hold=0.
  - At PRESCALE-1 it wraps to 0 and generates an internal step.
  - en=0 forces the prescaler to 0.
  - hold=1 keeps its current value.
- Step, phase R2G (falling channel val0, rising channel val1):
  - If val0 > STEP: val0 -= STEP, val1 += STEP.
  - Else: val0=0, val1=MAX_LEVEL, phase -> G2B.
- Step, phase G2B: same rule with val1 falling, val2 rising; phase -> B2R.
- Step, phase B2R: same rule with val2 falling, val0 rising; phase -> R2G and wrap=1 for that cycle.
- Invariants:
  - The sum of the falling and rising channels equals MAX_LEVEL at all times.
  - The third channel is 0.
  - No channel ever exceeds MAX_LEVEL or underflows.
  - Arithmetic is 9-bit internally and the comparison happens before the subtract.
- Output timing: all outputs are registered. load and wrap assert in the same cycle the new values appear, one clock after the prescaler wrap.
- restart=1:
  - On the next edge: values and phase return to the reset values, the prescaler is cleared, and load=1.
  - restart takes priority over a coincident step.
  - wrap is not asserted on restart.
- hold=1 coincident with the prescaler at PRESCALE-1: no step occurs; the step fires on the first cycle after hold deasserts.
- Reset asserted mid-step: asynchronous clear; no load is emitted until the release sequence above.
- Full colour cycle length: 3*ceil(MAX_LEVEL/STEP) steps.

Optional Feature:
- Macro: RGB_FADE_GAMMA_EN.
- Defined:
  - val0..2 pass through a registered 256-entry gamma-2.2 ROM: out=round(255*(x/255)^2.2). Examples: 0->0, 128->56, 255->255.
  - This adds exactly one cycle of latency. load, wrap and phase are delayed one cycle so they stay aligned with the gamma-corrected values.
  - The invariants above apply to the pre-gamma values only.
- Undefined: linear outputs, no ROM, latency as stated in Behaviour.

Test Plan:
- Reset release, PRESCALE=4, STEP=1, MAX_LEVEL=255, en=1 -> the first clock after release gives load=1 with 255/0/0. Four clocks later load=1 with 254/1/0. load pulses every 4 clocks thereafter.
- Same configuration, run 765 steps (3060 clocks) -> the phase sequence goes 0->1->2->0, and wrap pulses exactly once with values 255/0/0. At every load, sum=255 and one channel is 0.
- MAX_LEVEL=128, STEP=5 -> after 25 steps val0=3 and val1=125. Step 26 gives 0/128/0 with phase=1. No channel is ever above 128.
- hold=1 for 10 clocks starting at prescaler=2 -> no load during the hold, and the next load comes 2 clocks after release. en=0 then en=1 -> the next load comes PRESCALE+1 clocks later.
- restart coincident with a step mid-G2B -> the next cycle shows 255/0/0, phase=0, load=1 and wrap=0. resetn pulsed low mid-run -> outputs clear immediately (asynchronously) to the reset values.
- With RGB_FADE_GAMMA_EN, PRESCALE=4, STEP=1, run until the pre-gamma values are 127/128/0 -> the outputs read 55/56/0 one cycle after the pre-gamma step, and load is aligned with that update.
